// File: rtl/alu_exec_pkg.sv
// Shared encodings for the MIPS ALU execute stage: funct/ALUop codes, control codes, FSM states.
// Optional divider support is selected with the ALU_DIV_EN macro.
package alu_exec_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_MFHI = 4'b0100;
  localparam logic [3:0] C_MFLO = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_MUL  = 4'b1010;
  localparam logic [3:0] C_DIV  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_XOR  = 4'b1101;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  function automatic logic [3:0] decode_ctrl(input logic [1:0] aluop, input logic [5:0] funct);
    logic [3:0] c;
    c = C_ILL;
    case (aluop)
      OP_ADD: c = C_ADD;
      OP_SUB: c = C_SUB;
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU:   c = C_ADD;
          F_SUB, F_SUBU:   c = C_SUB;
          F_AND:           c = C_AND;
          F_OR:            c = C_OR;
          F_XOR:           c = C_XOR;
          F_NOR:           c = C_NOR;
          F_SLT:           c = C_SLT;
          F_SLTU:          c = C_SLTU;
          F_MFHI:          c = C_MFHI;
          F_MFLO:          c = C_MFLO;
          F_MULT, F_MULTU: c = C_MUL;
`ifdef ALU_DIV_EN
          F_DIV, F_DIVU:   c = C_DIV;
`endif
          default:         c = C_ILL;
        endcase
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle on operand magnitudes.
// The divider datapath exists only when ALU_DIV_EN is defined.
module alu_muldiv_seq
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             is_signed,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod, prod_next, prod_fix;
  logic [WIDTH-1:0]   mcand, a_mag, b_mag;
  logic [WIDTH:0]     psum;
  logic               neg_prod;

  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  assign last  = step && (cnt == LAST_CNT);

  // Upper half accumulates the multiplicand whenever the multiplier LSB shifting out is set.
  assign psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {psum, prod[WIDTH-1:1]};
  assign prod_fix  = neg_prod ? -prod_next : prod_next;

`ifdef ALU_DIV_EN
  logic             op_div, neg_quo, neg_rem, div_zero;
  logic [WIDTH-1:0] rem, quo, dsor, a_raw, rem_next, quo_next;
  logic [WIDTH:0]   shifted, diff;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsor};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // Divide-by-zero bypasses the iterated values: all-ones quotient, dividend as remainder.
  always_comb begin
    hi_res = prod_fix[2*WIDTH-1:WIDTH];
    lo_res = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = neg_rem ? -rem_next : rem_next;
        lo_res = neg_quo ? -quo_next : quo_next;
      end
    end
  end
`else
  assign hi_res = prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res = prod_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      neg_prod <= 1'b0;
`ifdef ALU_DIV_EN
      op_div   <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dsor     <= '0;
      a_raw    <= '0;
`endif
    end else if (start) begin
      cnt      <= '0;
      prod     <= {{WIDTH{1'b0}}, b_mag};
      mcand    <= a_mag;
      neg_prod <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DIV_EN
      op_div   <= is_div;
      neg_quo  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= is_signed && a[WIDTH-1];
      div_zero <= (b == '0);
      rem      <= '0;
      quo      <= a_mag;
      dsor     <= b_mag;
      a_raw    <= a;
`endif
    end else if (step) begin
      cnt      <= cnt + 1'b1;
      prod     <= prod_next;
`ifdef ALU_DIV_EN
      rem      <= rem_next;
      quo      <= quo_next;
`endif
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS EX-stage ALU: decode, registered single-cycle ops, HI/LO and an iterative MUL/DIV sequencer.
// Define ALU_DIV_EN to build the divider; otherwise div/divu decode as illegal.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              ready_o,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal
);

  state_t           state, state_next;
  logic             accept, start_mul, start_div, seq_last;
  logic [3:0]       ctrl_dec;
  logic [WIDTH-1:0] alu_out, seq_hi, seq_lo;

  assign busy      = (state != S_IDLE);
  assign ready_o   = ~busy;
  assign accept    = valid_i & ready_o;
  assign ctrl_dec  = decode_ctrl(ALUop, funct);
  assign start_mul = accept && (ctrl_dec == C_MUL);
  assign start_div = accept && (ctrl_dec == C_DIV);

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (start_mul | start_div),
    .step      (busy),
    .is_signed (~funct[0]),
`ifdef ALU_DIV_EN
    .is_div    (ctrl_dec == C_DIV),
`endif
    .a         (a),
    .b         (b),
    .last      (seq_last),
    .hi_res    (seq_hi),
    .lo_res    (seq_lo)
  );

  always_comb begin
    alu_out = '0;
    case (ctrl_dec)
      C_ADD:   alu_out = a + b;
      C_SUB:   alu_out = a - b;
      C_AND:   alu_out = a & b;
      C_OR:    alu_out = a | b;
      C_XOR:   alu_out = a ^ b;
      C_NOR:   alu_out = ~(a | b);
      C_SLT:   alu_out = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      C_SLTU:  alu_out = {{(WIDTH-1){1'b0}}, a < b};
      C_MFHI:  alu_out = hi;
      C_MFLO:  alu_out = lo;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_mul)      state_next = S_MUL;
        else if (start_div) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (seq_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Accepts only happen while idle, so they never collide with a sequencer completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      alu_ctrl <= '0;
      illegal  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (seq_last) begin
        hi   <= seq_hi;
        lo   <= seq_lo;
        done <= 1'b1;
      end else if (accept) begin
        alu_ctrl <= CTRL_W'(ctrl_dec);
        illegal  <= (ctrl_dec == C_ILL);
        if (!(start_mul || start_div)) begin
          result <= alu_out;
          zero   <= (alu_out == '0);
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32): directed cases plus random ops against a reference model.
// Expectations for div/divu follow whether ALU_DIV_EN is defined.
module tb_alu_exec_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [3:0]   ctrl;
    logic         ill;
    logic [1:0]   kind;
    logic [W-1:0] res;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, valid_i;
  logic [1:0]   ALUop;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         ready_o, busy, done, zero, illegal;
  logic [W-1:0] result, hi, lo;
  logic [3:0]   alu_ctrl;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi, m_lo, m_result;
  logic [5:0]   flist [16];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ALUop    (ALUop),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .ready_o  (ready_o),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .hi       (hi),
    .lo       (lo),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                               input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    valid_i = v; ALUop = op; funct = f; a = x; b = y;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  function automatic exp_t modelOp(input logic [1:0] op, input logic [5:0] f,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] h, input logic [W-1:0] l);
    exp_t e;
    e = '{ctrl: 4'hF, ill: 1'b1, kind: 2'd0, res: '0};
    if (op == 2'b00) begin
      e.ctrl = 4'b0010; e.ill = 1'b0; e.res = x + y;
    end else if (op == 2'b01) begin
      e.ctrl = 4'b0110; e.ill = 1'b0; e.res = x - y;
    end else if (op == 2'b10) begin
      e.ill = 1'b0;
      case (f)
        6'h20, 6'h21: begin e.ctrl = 4'b0010; e.res = x + y; end
        6'h22, 6'h23: begin e.ctrl = 4'b0110; e.res = x - y; end
        6'h24: begin e.ctrl = 4'b0000; e.res = x & y; end
        6'h25: begin e.ctrl = 4'b0001; e.res = x | y; end
        6'h26: begin e.ctrl = 4'b1101; e.res = x ^ y; end
        6'h27: begin e.ctrl = 4'b1100; e.res = ~(x | y); end
        6'h2A: begin e.ctrl = 4'b0111; e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; end
        6'h2B: begin e.ctrl = 4'b1000; e.res = (x < y) ? 32'd1 : 32'd0; end
        6'h10: begin e.ctrl = 4'b0100; e.res = h; end
        6'h12: begin e.ctrl = 4'b0101; e.res = l; end
        6'h18, 6'h19: begin e.ctrl = 4'b1010; e.kind = 2'd1; end
`ifdef ALU_DIV_EN
        6'h1A, 6'h1B: begin e.ctrl = 4'b1011; e.kind = 2'd2; end
`endif
        default: begin e.ctrl = 4'hF; e.ill = 1'b1; e.res = '0; end
      endcase
    end
    return e;
  endfunction

  task automatic modelLong(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sx, sy, p, q, r;
    sx = f[0] ? longint'(x) : longint'($signed(x));
    sy = f[0] ? longint'(y) : longint'($signed(y));
    if (!f[1]) begin
      p = sx * sy;
      eh = p[63:32]; el = p[31:0];
    end else if (y == '0) begin
      eh = x; el = '1;
    end else begin
      q = sx / sy; r = sx % sy;
      eh = r[31:0]; el = q[31:0];
    end
  endtask

  task automatic doSingle(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = modelOp(op, f, x, y, m_hi, m_lo);
    applyStimulus(1'b1, op, f, x, y);
    m_result = e.res;
    checkOutput({tag, "_result"}, result, e.res);
    checkOutput({tag, "_zero"}, zero, (e.res == '0));
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_ctrl"}, alu_ctrl, e.ctrl);
    checkOutput({tag, "_illegal"}, illegal, e.ill);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_hi"}, hi, m_hi);
    checkOutput({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic doLong(input string tag, input logic [5:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit inject);
    logic [W-1:0] eh, el;
    logic [3:0]   ectrl;
    int           cycles;
    modelLong(f, x, y, eh, el);
    ectrl = f[1] ? 4'b1011 : 4'b1010;
    applyStimulus(1'b1, 2'b10, f, x, y);
    checkOutput({tag, "_busy_start"}, busy, 1'b1);
    checkOutput({tag, "_ready_start"}, ready_o, 1'b0);
    checkOutput({tag, "_ctrl_start"}, alu_ctrl, ectrl);
    checkOutput({tag, "_done_start"}, done, 1'b0);
    cycles = 1;
    // Operands wander while busy; an add request mid-op must be dropped.
    for (int i = 0; i < 100 && busy; i++) begin
      valid_i = inject && (i == 4);
      ALUop = 2'b00; funct = 6'h20; a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      if (busy) cycles++;
    end
    valid_i = 1'b0;
    m_hi = eh; m_lo = el;
    checkOutput({tag, "_busy_cycles"}, cycles, W);
    checkOutput({tag, "_ready_end"}, ready_o, 1'b1);
    checkOutput({tag, "_done_end"}, done, 1'b1);
    checkOutput({tag, "_hi"}, hi, eh);
    checkOutput({tag, "_lo"}, lo, el);
    checkOutput({tag, "_result_kept"}, result, m_result);
    checkOutput({tag, "_ctrl_kept"}, alu_ctrl, ectrl);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic doOp(input string tag, input logic [1:0] op, input logic [5:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = modelOp(op, f, x, y, m_hi, m_lo);
    if (e.kind != 2'd0) doLong(tag, f, x, y, 1'b0);
    else                doSingle(tag, op, f, x, y);
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic [1:0]   op;
    logic [5:0]   f;
    int           sel;
    bit           done_seen;

    flist = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
    reset = 1'b1; valid_i = 1'b0; ALUop = 2'b00; funct = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_result", result, '0);
    checkOutput("rst_zero", zero, 1'b0);
    checkOutput("rst_hilo", {hi, lo}, '0);
    checkOutput("rst_ctrl", alu_ctrl, 4'h0);
    checkOutput("rst_illegal", illegal, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", ready_o, 1'b1);
    m_hi = '0; m_lo = '0; m_result = '0;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed single-cycle ops");
    doSingle("sub_5_7", 2'b10, 6'h22, 32'd5, 32'd7);
    checkOutput("sub_5_7_const", result, 32'hFFFF_FFFE);
    doSingle("slt", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
    checkOutput("slt_const", result, 32'd1);
    doSingle("sltu", 2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1);
    checkOutput("sltu_const", result, 32'd0);
    doSingle("beq", 2'b01, 6'h3F, 32'd9, 32'd9);
    checkOutput("beq_zero_const", zero, 1'b1);
    doSingle("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd2);

    $display("[TB] mult with ignored request while busy");
    doLong("mult", 6'h18, 32'hFFFF_FFFD, 32'd7, 1'b1);
    checkOutput("mult_hi_const", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo_const", lo, 32'hFFFF_FFEB);
    doSingle("mflo", 2'b10, 6'h12, 32'd0, 32'd0);
    checkOutput("mflo_const", result, 32'hFFFF_FFEB);
    doSingle("mfhi", 2'b10, 6'h10, 32'd0, 32'd0);

`ifdef ALU_DIV_EN
    $display("[TB] divider");
    doLong("divu", 6'h1B, 32'd100, 32'd7, 1'b0);
    checkOutput("divu_lo_const", lo, 32'd14);
    checkOutput("divu_hi_const", hi, 32'd2);
    doLong("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("div_lo_const", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi_const", hi, 32'hFFFF_FFFF);
    doLong("divu_by0", 6'h1B, 32'd5, 32'd0, 1'b0);
    checkOutput("div0_lo_const", lo, 32'hFFFF_FFFF);
    checkOutput("div0_hi_const", hi, 32'd5);
`else
    $display("[TB] divider absent: div decodes illegal");
    doSingle("div_ill", 2'b10, 6'h1A, 32'd100, 32'd7);
    checkOutput("div_ill_const", illegal, 1'b1);
    doSingle("divu_ill", 2'b10, 6'h1B, 32'd100, 32'd7);
`endif

    $display("[TB] illegal decodes");
    doSingle("funct_3f", 2'b10, 6'h3F, 32'd3, 32'd4);
    checkOutput("funct_3f_ill_const", illegal, 1'b1);
    doSingle("aluop_11", 2'b11, 6'h20, 32'd3, 32'd4);

    $display("[TB] reset during mult");
    doLong("mult2", 6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'h18, 32'h0000_1234, 32'hFFFF_0001);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_hi = '0; m_lo = '0; m_result = '0;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_ready", ready_o, 1'b1);
    checkOutput("midrst_hilo", {hi, lo}, '0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_result", result, '0);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1'b1;
    end
    checkOutput("midrst_no_done", done_seen, 1'b0);
    checkOutput("midrst_hilo_after", {hi, lo}, '0);

    $display("[TB] random back-to-back ops");
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 19);
      x = $urandom;
      y = ($urandom_range(0, 4) == 0) ? x : $urandom;
      if ($urandom_range(0, 9) == 0) y = '0;
      if (sel < 16) begin
        op = 2'b10; f = flist[sel];
      end else if (sel == 16) begin
        op = 2'b10; f = 6'($urandom);
      end else begin
        op = (sel == 17) ? 2'b00 : (sel == 18) ? 2'b01 : 2'b11;
        f = 6'($urandom);
      end
      doOp("rnd", op, f, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
